// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the multichannel PWM block: register field
// encodings, CTRL bit positions, prescaler width and the per-channel
// output drive function.
package pwm_pkg;

    typedef enum logic [1:0] {
        FIELD_DUTY  = 2'd0,
        FIELD_CTRL  = 2'd1,
        FIELD_PRESC = 2'd2,
        FIELD_RSVD  = 2'd3
    } field_e;

    localparam int CTRL_OUT_EN = 0;
    localparam int CTRL_PWM_EN = 1;
    localparam int PRESC_W     = 8;

    // Output mux: disabled -> 0, enabled without PWM -> 1, else PWM level.
    function automatic logic pwm_drive(input logic out_en,
                                       input logic pwm_en,
                                       input logic level);
        return out_en & (~pwm_en | level);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
// One PWM output: duty register(s), CTRL bits, comparator against the
// shared period counter and the registered output.
//
// Build option: PWM_SHADOW_EN
//   defined   : DUTY writes go to a shadow register that is copied into the
//               active register on the period-boundary strobe i_pb.
//   undefined : DUTY writes go straight to the active register; no i_pb port.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_cnt         shared period counter
//   i_pb          period-boundary strobe (PWM_SHADOW_EN builds only)
//   i_duty_we     write strobe for this channel's DUTY field
//   i_ctrl_we     write strobe for this channel's CTRL field
//   i_wr_data     write data
//   o_out         registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_cnt,
`ifdef PWM_SHADOW_EN
    input  logic             i_pb,
`endif
    input  logic             i_duty_we,
    input  logic             i_ctrl_we,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_out
);

    logic [WIDTH-1:0] r_duty_active;
    logic             r_out_en;
    logic             r_pwm_en;
    logic             r_out_p1;
    logic             w_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en <= 1'b0;
            r_pwm_en <= 1'b0;
        end else if (i_ctrl_we) begin
            r_out_en <= i_wr_data[CTRL_OUT_EN];
            r_pwm_en <= i_wr_data[CTRL_PWM_EN];
        end
    end

`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0] r_duty_shadow;

    // A write landing on the boundary edge only reaches the shadow; the
    // active register takes the shadow value held before that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_shadow <= '0;
            r_duty_active <= '0;
        end else begin
            if (i_duty_we)
                r_duty_shadow <= i_wr_data;
            if (i_pb)
                r_duty_active <= r_duty_shadow;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            r_duty_active <= '0;
        else if (i_duty_we)
            r_duty_active <= i_wr_data;
    end
`endif

    // The counter never reaches 2^WIDTH-1, so a full-scale duty stays high.
    assign w_level = (i_cnt < r_duty_active);

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (rst)
            r_out_p1 <= 1'b0;
        else
            r_out_p1 <= pwm_drive(r_out_en, r_pwm_en, w_level);
    end

    assign o_out = r_out_p1;

endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel
// CHANNELS independent PWM outputs at WIDTH-bit resolution sharing one
// 8-bit clock prescaler and one period counter. Registers are written
// through an addressed port: wr_addr = {channel, field[1:0]}.
//   field 0 DUTY, field 1 CTRL (bit0 out_en, bit1 pwm_en),
//   field 2 PRESC (channel 0 only), field 3 reserved.
//
// Build option: PWM_SHADOW_EN (see pwm_channel) selects double-buffered
// duty registers loaded at the period boundary.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   wr_en          one-cycle write strobe
//   wr_addr        {channel, field}
//   wr_data        write data
//   out            registered PWM outputs
//   period_start   one-cycle pulse after each counter wrap to 0
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 16,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] out,
    output logic                period_start
);

    // Last counter value before the wrap: 2^WIDTH-2.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [PRESC_W-1:0]  r_pc;
    logic [PRESC_W-1:0]  r_presc;
    logic [WIDTH-1:0]    r_cnt;
    logic                r_period_start;

    logic [31:0]         w_ch_idx;
    logic                w_ch_ok;
    field_e              w_field;
    logic [CHANNELS-1:0] w_duty_we;
    logic [CHANNELS-1:0] w_ctrl_we;
    logic                w_presc_we;
    logic                w_tick;
    logic                w_pb;

    // Address decode. The channel index is widened so that CHANNELS=1
    // (no channel bits in the address) needs no special case.
    assign w_ch_idx = 32'(wr_addr >> 2);
    assign w_field  = field_e'(wr_addr[1:0]);
    assign w_ch_ok  = (w_ch_idx < 32'(CHANNELS));

    always_comb begin
        w_duty_we = '0;
        w_ctrl_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && w_ch_ok && (w_ch_idx == 32'(i))) begin
                w_duty_we[i] = (w_field == FIELD_DUTY);
                w_ctrl_we[i] = (w_field == FIELD_CTRL);
            end
        end
    end

    assign w_presc_we = wr_en && (w_field == FIELD_PRESC) && (w_ch_idx == 32'd0);

    assign w_tick = (r_pc == r_presc);
    assign w_pb   = w_tick && (r_cnt == CNT_LAST);

    // Prescaler: a PRESC write restarts the divide from 0 so the new
    // divisor never produces a short first interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_presc <= '0;
        end else if (w_presc_we) begin
            r_presc <= PRESC_W'(wr_data);
            r_pc    <= '0;
        end else if (w_tick) begin
            r_pc    <= '0;
        end else begin
            r_pc    <= r_pc + 1'b1;
        end
    end

    // Period counter runs 0..2^WIDTH-2 so that duty 2^WIDTH-1 means 100%.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end

    // ---- period_start register stage ----
    always_ff @(posedge clk) begin
        if (rst)
            r_period_start <= 1'b0;
        else
            r_period_start <= w_pb;
    end

    assign period_start = r_period_start;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_cnt     (r_cnt),
`ifdef PWM_SHADOW_EN
            .i_pb      (w_pb),
`endif
            .i_duty_we (w_duty_we[g]),
            .i_ctrl_we (w_ctrl_we[g]),
            .i_wr_data (wr_data),
            .o_out     (out[g])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Testbench for pwm_multichannel (CHANNELS=16, WIDTH=8).
// A reference model updated on every clock edge pushes the expected
// {out, period_start} into a queue; a monitor pops and compares one entry
// per cycle. Directed tasks additionally measure period length and high
// time of single channels and compare them with closed-form values.
module tb_pwm_multichannel;

    localparam int CH     = 16;
    localparam int W      = 8;
    localparam int AW     = 6;
    localparam int STEPS  = 255;      // counter values per period: 2^W-1
    localparam int LIMIT  = 4000;     // bound on any wait, in cycles

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [CH-1:0] out;
    logic          period_start;

    int checks = 0;
    int errors = 0;

    pwm_multichannel #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CH-1:0] o;
        logic          ps;
    } exp_t;

    exp_t q[$];

    int m_pc, m_cnt, m_presc;
    int m_shad[CH];
    int m_act[CH];
    bit m_oe[CH];
    bit m_pe[CH];
    bit m_live = 0;

    initial forever begin
        exp_t e;
        bit   tick, pb;
        int   ch, fld;
        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_cnt = 0; m_presc = 0;
            for (int c = 0; c < CH; c++) begin
                m_shad[c] = 0; m_act[c] = 0; m_oe[c] = 0; m_pe[c] = 0;
            end
            m_live = 1;
            e.o = '0; e.ps = 1'b0;
            q.push_back(e);
        end else if (m_live) begin
            for (int c = 0; c < CH; c++)
                e.o[c] = m_oe[c] ? (m_pe[c] ? (m_cnt < m_act[c]) : 1'b1) : 1'b0;
            tick = (m_pc == m_presc);
            pb   = tick && (m_cnt == STEPS - 1);
            e.ps = pb;
            q.push_back(e);
            if (tick) m_cnt = (m_cnt + 1) % STEPS;
            m_pc = tick ? 0 : m_pc + 1;
`ifdef PWM_SHADOW_EN
            if (pb)
                for (int c = 0; c < CH; c++) m_act[c] = m_shad[c];
`endif
            if (wr_en) begin
                ch  = int'(wr_addr) / 4;
                fld = int'(wr_addr) % 4;
                if (ch < CH) begin
                    case (fld)
`ifdef PWM_SHADOW_EN
                        0: m_shad[ch] = int'(wr_data);
`else
                        0: m_act[ch]  = int'(wr_data);
`endif
                        1: begin m_oe[ch] = wr_data[0]; m_pe[ch] = wr_data[1]; end
                        2: if (ch == 0) begin m_presc = int'(wr_data) % 256; m_pc = 0; end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (out !== e.o || period_start !== e.ps) begin
                errors++;
                $display("FAIL cycle_out t=%0t out=%h ps=%b expected out=%h ps=%b",
                         $time, out, period_start, e.o, e.ps);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Caller is at a negedge; drives one write cycle, returns at the next negedge.
    task automatic wr(input int ch, input int fld, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(ch * 4 + fld);
        wr_data = W'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_ps(output int n);
        bit seen = 0;
        n = 0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (period_start === 1'b1) seen = 1;
        end
        if (!seen) chk("wait_ps_timeout", 0, 1);
    endtask

    // Samples up to and including the next period_start.
    task automatic span(input int ch, output int per, output int hi);
        bit seen = 0;
        per = 0; hi = 0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            @(posedge clk); #1;
            per++;
            if (out[ch] === 1'b1) hi++;
            if (period_start === 1'b1) seen = 1;
        end
        if (!seen) chk("span_timeout", 0, 1);
    endtask

    task automatic measure(input int ch, output int per, output int hi);
        int n;
        wait_ps(n);
        span(ch, per, hi);
    endtask

    task automatic count_n(input int ch, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out[ch] === 1'b1) hi++;
        end
    endtask

    task automatic wait_cnt(input int v);
        bit hit = 0;
        for (int i = 0; i < LIMIT && !hit; i++) begin
            @(negedge clk);
            if (m_cnt == v) hit = 1;
        end
        if (!hit) chk("wait_cnt_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, per, hi;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset with random writes in flight
        repeat (3) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = AW'($urandom_range(0, 63));
            wr_data = W'($urandom);
        end
        @(negedge clk);
        chk("reset_out", int'(out), 0);
        chk("reset_ps", int'(period_start), 0);
        rst = 1'b0; wr_en = 1'b0;
        wait_ps(n);
        chk("first_period_start", n, 255);

        // Duty sweep on channel 3
        @(negedge clk);
        wr(3, 1, 3);
        wr(3, 0, 'h80);
        measure(3, per, hi);
        chk("sweep80_period", per, 255);
        chk("sweep80_high", hi, 128);
        @(negedge clk); wr(3, 0, 'h00);
        measure(3, per, hi);
        chk("sweep00_high", hi, 0);
        @(negedge clk); wr(3, 0, 'hFF);
        measure(3, per, hi);
        chk("sweepFF_high", hi, 255);

        // Static modes on channel 5
        @(negedge clk); wr(5, 1, 1);
        measure(5, per, hi);
        chk("static_oe_high", hi, 255);
        @(negedge clk); wr(5, 1, 2);
        measure(5, per, hi);
        chk("static_pwm_only_high", hi, 0);
        @(negedge clk); wr(5, 1, 0);
        measure(5, per, hi);
        chk("static_off_high", hi, 0);

        // Prescaler
        @(negedge clk);
        wr(0, 2, 3);
        wr(3, 0, 'h40);
        measure(3, per, hi);
        chk("presc3_period", per, 1020);
        chk("presc3_high", hi, 256);
        @(negedge clk); wr(2, 2, 0);
        measure(3, per, hi);
        chk("presc_ch2_ignored_period", per, 1020);
        chk("presc_ch2_ignored_high", hi, 256);

        // Shadow behaviour: mid-period write, then write on the boundary edge
        @(negedge clk);
        wr(0, 2, 0);
        wr(3, 0, 'h20);
        measure(3, per, hi);
        chk("duty20_high", hi, 32);
        wait_cnt('h50);
        wr(3, 0, 'hC0);
        span(3, per, hi);
`ifdef PWM_SHADOW_EN
        chk("midwrite_partial_high", hi, 0);
`else
        chk("midwrite_partial_high", hi, 111);
`endif
        span(3, per, hi);
        chk("midwrite_next_high", hi, 192);
        wait_cnt(STEPS - 1);
        wr(3, 0, 'h60);
        count_n(3, STEPS, hi);
`ifdef PWM_SHADOW_EN
        chk("pbwrite_period1_high", hi, 192);
`else
        chk("pbwrite_period1_high", hi, 96);
`endif
        count_n(3, STEPS, hi);
        chk("pbwrite_period2_high", hi, 96);

        // Reset mid-period with channels active
        @(negedge clk); wr(5, 1, 3);
        wait_cnt('h90);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_out", int'(out), 0);
        chk("midreset_ps", int'(period_start), 0);
        @(negedge clk);
        rst = 1'b0;
        wr(3, 1, 3);
        wr(5, 1, 3);
        measure(3, per, hi);
        chk("post_reset_period", per, 255);
        chk("post_reset_ch3_high", hi, 0);
        measure(5, per, hi);
        chk("post_reset_ch5_high", hi, 0);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(0, 63));
                wr_data = W'($urandom);
                if (wr_addr[1:0] == 2'd2) wr_data = wr_data & 8'h03;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised PWM generator, successor to the fixed 16-output, 8-bit PWM peripheral. Provides CHANNELS independent outputs at WIDTH-bit resolution, a programmable clock prescaler, and double-buffered per-channel duty registers. Written through an addressed register port driven by the SPI register front end. Drives the design's output pins directly.

## Interface
- CHANNELS, 16: number of PWM outputs, 1..32.
- WIDTH, 8: duty and counter resolution in bits, 2..16.
- ADDR_W, $clog2(CHANNELS)+2: register address width, derived and not to be overridden.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe.
- wr_addr  in  ADDR_W  {channel, field[1:0]}.
- wr_data  in  WIDTH  write data.
- out  out  CHANNELS  PWM outputs, registered.
- period_start  out  1  one-cycle pulse on each counter wrap to 0.

## Operation
- Fields:
  - 0 = DUTY, WIDTH bits.
  - 1 = CTRL: bit0 out_en, bit1 pwm_en; upper bits ignored.
  - 2 = PRESC, low 8 bits. Accepted only with channel 0; ignored for other channels.
  - 3 = reserved, write ignored.
- Writes to channel index >= CHANNELS are ignored.
- Prescaler: 8-bit counter `pc` counts 0..PRESC. `tick` is asserted when pc==PRESC, and pc then returns to 0.
- Period counter `cnt` (WIDTH bits) advances on `tick` over 0..2^WIDTH-2, then wraps to 0.
  - Period = (2^WIDTH-1)*(PRESC+1) clk cycles.
- Per-channel level is (cnt < duty_active). Consequences:
  - duty 0: always low.
  - duty 2^WIDTH-1: always high.
  - duty d: high for d*(PRESC+1) cycles per period.
- Output mux per channel:
  - out_en=0: drive 0.
  - out_en=1, pwm_en=0: drive 1.
  - both set: drive PWM level.
- Reset values:
  - out = 0, period_start = 0.
  - cnt = 0, pc = 0, PRESC = 0.
  - All duty registers (shadow and active) = 0.
  - All CTRL registers = 0.
- A write to PRESC also clears pc, so the new divisor starts from a clean count.

## Timing
- Registers update on the clk edge where wr_en=1.
- CTRL takes effect on `out` one cycle after the write edge.
- period_start is asserted in the cycle after the edge at which cnt wraps to 0, i.e. when cnt==0 and pc==0.
- Period boundary (PB) = the edge at which `tick` causes cnt to go from 2^WIDTH-2 to 0. At PB, every duty_active loads from its duty_shadow.
- Write to DUTY coincident with PB: the new value goes to shadow only and becomes active at the next PB. The old shadow value is the one loaded.
- Output latency: `out` reflects (cnt, duty_active, CTRL) with one register stage.
- Reset asserted mid-period: all state returns to reset values on the next edge, and `out` is 0 in the following cycle. After release, counting restarts at cnt=0.

## Configuration
- PWM_SHADOW_EN defined (default build): DUTY writes land in the shadow register and are applied at PB. No partial or glitched periods.
- PWM_SHADOW_EN undefined:
  - No shadow registers.
  - DUTY writes go to duty_active directly and take effect on `out` one cycle after the write edge, even mid-period.
  - The PB load logic is absent.
- CTRL and PRESC behaviour is identical in both builds.

## Structure
- Package `pwm_pkg`:
  - Field encodings FIELD_DUTY=0, FIELD_CTRL=1, FIELD_PRESC=2.
  - CTRL bit indices CTRL_OUT_EN=0, CTRL_PWM_EN=1.
  - PRESC_W=8.
- Sub-module `pwm_channel`, generated CHANNELS times:
  - Contents: duty shadow/active registers, CTRL bits, comparator, output register.
  - Inputs: shared cnt, PB strobe, decoded write enables.
- The top level holds address decode, prescaler, period counter and period_start.

## Test plan
- Reset: hold rst for 3 cycles with random writes -> out=0, period_start=0. After release, the first period_start occurs 255 cycles after the counter starts (WIDTH=8, PRESC=0).
- Duty sweep, ch3: CTRL=3, DUTY=0x80, PRESC=0 -> out[3] high 128 / low 127 cycles per 255-cycle period. DUTY=0x00 gives always low; DUTY=0xFF gives always high.
- Static modes, ch5: CTRL=1 -> out[5] constant 1. CTRL=2 or CTRL=0 -> out[5] constant 0. All other outputs unaffected.
- Prescaler: PRESC=3, DUTY=0x40 -> period 1020 cycles, high 256 cycles. PRESC written on channel 2 -> ignored, period unchanged.
- Shadow: with PWM_SHADOW_EN, write DUTY 0x20->0xC0 at cnt=0x50 -> current period keeps the 0x20 shape; the next period is 0xC0. Repeat with the write on the PB edge -> change is deferred one more period. Without the macro, out changes one cycle after the write.
- Reset mid-period at cnt=0x90 with channels active -> out=0 the cycle after reset. All duties read back as 0 behaviour (outputs stay low with CTRL=3 after release).
